dmem: RTL and testbench

// - Byte-addressable 128-byte data memory for the multi-cycle MIPS CPU (load/store path).
// - Stored as 32 little-endian 32-bit words; supports word, halfword and byte accesses.
// - Sub-word loads are zero- or sign-extended to 32 bits.

---
 rtl/dmem.sv | 111 +++++++++++
 tb/tb_dmem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// Byte-addressable data memory: 32 little-endian words, word/half/byte stores and extended loads.
// Define DMEM_RDATA_REG_EN to register rdata (1-cycle load latency); default is a combinational read.
`default_nettype none

module dmem #(
  parameter int ADDR_W = 7,
  parameter int WORDS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic              is_byte,
  input  logic              is_half,
  input  logic              is_signed,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0]       r_mem [WORDS];

  logic [ADDR_W-3:0] _4byte_addr;
  logic [1:0]        _4byte_inner_pos;
  logic [31:0]       _4byte;
  logic [15:0]       _half;
  logic [7:0]        _byte;

  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_wword;
  logic [31:0]       w_load;

  // Select and extend the load value; an illegal half arrives here as 0 and stays 0.
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [15:0] half,
                                           input logic [7:0]  byt,
                                           input logic        b,
                                           input logic        h,
                                           input logic        s);
    if (b)
      return s ? {{24{byt[7]}}, byt} : {24'h0, byt};
    if (h)
      return s ? {{16{half[15]}}, half} : {16'h0, half};
    return word;
  endfunction

  assign _4byte_addr      = address[ADDR_W-1:2];
  assign _4byte_inner_pos = address[1:0];
  assign _4byte           = r_mem[_4byte_addr];

  always_comb begin
    _byte = 8'h0;
    _half = 16'h0;
    case (_4byte_inner_pos)
      2'd0: begin _byte = _4byte[7:0];   _half = _4byte[15:0];  end
      2'd1: begin _byte = _4byte[15:8];  _half = _4byte[23:8];  end
      2'd2: begin _byte = _4byte[23:16]; _half = _4byte[31:16]; end
      default: begin _byte = _4byte[31:24]; _half = 16'h0; end
    endcase
  end

  // Byte enables and lane-aligned store data; a half store at lane 3 enables nothing.
  always_comb begin
    w_be     = 4'hf;
    w_wlanes = wdata;
    if (is_byte) begin
      w_be     = 4'b0001 << _4byte_inner_pos;
      w_wlanes = {24'h0, wdata[7:0]} << {_4byte_inner_pos, 3'b000};
    end else if (is_half) begin
      w_be     = (_4byte_inner_pos == 2'd3) ? 4'b0000 : (4'b0011 << _4byte_inner_pos);
      w_wlanes = {16'h0, wdata[15:0]} << {_4byte_inner_pos, 3'b000};
    end
  end

  always_comb begin
    w_wword = _4byte;
    for (int k = 0; k < 4; k++)
      if (w_be[k])
        w_wword[8*k +: 8] = w_wlanes[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++)
        r_mem[i[ADDR_W-3:0]] <= 32'h0;
    end else if (write) begin
      r_mem[_4byte_addr] <= w_wword;
    end
  end

  assign w_load = read ? f_extend(_4byte, _half, _byte, is_byte, is_half, is_signed) : 32'h0;

`ifdef DMEM_RDATA_REG_EN
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst)
      r_rdata <= 32'h0;
    else
      r_rdata <= w_load;
  end

  assign rdata = r_rdata;
`else
  assign rdata = w_load;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem.sv
// Directed bench for dmem; samples rdata one cycle later when DMEM_RDATA_REG_EN is defined.
`timescale 1ns/1ps

module tb_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        is_byte = 1'b0;
  logic        is_half = 1'b0;
  logic        is_signed = 1'b0;
  logic [6:0]  address = 7'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem #(.ADDR_W(7), .WORDS(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .read      (read),
    .is_byte   (is_byte),
    .is_half   (is_half),
    .is_signed (is_signed),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [6:0] a, input logic [31:0] d, input logic b, input logic h);
    @(negedge clk);
    address = a; wdata = d; is_byte = b; is_half = h; write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic load(input string tag, input logic [6:0] a, input logic b, input logic h,
                      input logic s, input logic [31:0] exp);
    @(negedge clk);
    address = a; is_byte = b; is_half = h; is_signed = s; read = 1'b1;
`ifdef DMEM_RDATA_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check(tag, rdata, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    load("rst_word0", 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Word stores and readback
    store(7'd60, 32'haabbccdd, 1'b0, 1'b0);
    store(7'd8,  32'h11223344, 1'b0, 1'b0);
    store(7'd44, 32'h12341234, 1'b0, 1'b0);
    load("word60", 7'd60, 1'b0, 1'b0, 1'b0, 32'haabbccdd);
    load("word8",  7'd8,  1'b0, 1'b0, 1'b0, 32'h11223344);
    load("word44", 7'd44, 1'b0, 1'b0, 1'b1, 32'h12341234);
    load("word63_unaligned", 7'd63, 1'b0, 1'b0, 1'b0, 32'haabbccdd);

    // Half stores at lane 1
    store(7'd12, 32'hc3ddee3c, 1'b0, 1'b0);
    store(7'd13, 32'hffffb0c0, 1'b0, 1'b1);
    store(7'd21, 32'h99887766, 1'b0, 1'b1);
    load("half13_u", 7'd13, 1'b0, 1'b1, 1'b0, 32'h0000b0c0);
    load("half13_s", 7'd13, 1'b0, 1'b1, 1'b1, 32'hffffb0c0);
    load("half21_u", 7'd21, 1'b0, 1'b1, 1'b0, 32'h00007766);
    load("half21_s", 7'd21, 1'b0, 1'b1, 1'b1, 32'h00007766);
    load("word12_after_half", 7'd12, 1'b0, 1'b0, 1'b0, 32'hc3b0c03c);
    load("word20_after_half", 7'd20, 1'b0, 1'b0, 1'b0, 32'h00776600);

    // Byte stores
    store(7'd8, 32'ha1a2a3a4, 1'b1, 1'b0);
    store(7'd8, 32'hb1b2b3b4, 1'b1, 1'b0);
    load("byte8_u", 7'd8, 1'b1, 1'b0, 1'b0, 32'h000000b4);
    load("byte8_s", 7'd8, 1'b1, 1'b0, 1'b1, 32'hffffffb4);
    load("word8_after_byte", 7'd8, 1'b0, 1'b0, 1'b0, 32'h112233b4);
    store(7'd11, 32'h0000007f, 1'b1, 1'b0);
    load("word8_after_byte11", 7'd8, 1'b0, 1'b0, 1'b0, 32'h7f2233b4);
    load("byte11_s", 7'd11, 1'b1, 1'b1, 1'b1, 32'h0000007f);
    load("half10_s", 7'd10, 1'b0, 1'b1, 1'b1, 32'h00007f22);
    load("half8_u",  7'd8,  1'b0, 1'b1, 1'b0, 32'h000033b4);

    // Illegal half at lane 3
    store(7'd15, 32'h00005555, 1'b0, 1'b1);
    load("word12_after_illegal", 7'd12, 1'b0, 1'b0, 1'b0, 32'hc3b0c03c);
    load("half15_u", 7'd15, 1'b0, 1'b1, 1'b0, 32'h0);
    load("half15_s", 7'd15, 1'b0, 1'b1, 1'b1, 32'h0);

    // read=0 forces zero
    store(7'd4, 32'h0badf00d, 1'b0, 1'b0);
    load("word4", 7'd4, 1'b0, 1'b0, 1'b0, 32'h0badf00d);
    @(negedge clk);
    read = 1'b0;
`ifdef DMEM_RDATA_REG_EN
    @(posedge clk);
`endif
    #1 check("read0", rdata, 32'h0);

    // Simultaneous write and read of one word: new data only after the edge
    store(7'd40, 32'h01020304, 1'b0, 1'b0);
    @(negedge clk);
    address = 7'd40; is_byte = 1'b0; is_half = 1'b0; wdata = 32'h600dcafe;
    write = 1'b1; read = 1'b1;
`ifdef DMEM_RDATA_REG_EN
    @(posedge clk);
    #1 write = 1'b0;
    check("rw_before_edge", rdata, 32'h01020304);
    @(posedge clk);
    #1 check("rw_after_edge", rdata, 32'h600dcafe);
`else
    #1 check("rw_before_edge", rdata, 32'h01020304);
    @(posedge clk);
    #1 write = 1'b0;
    check("rw_after_edge", rdata, 32'h600dcafe);
`endif

    // Reset clears contents and overrides write
    store(7'd0, 32'hdeadbeef, 1'b0, 1'b0);
    load("word0_before_rst", 7'd0, 1'b0, 1'b0, 1'b0, 32'hdeadbeef);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load("word0_after_rst", 7'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    load("word60_after_rst", 7'd60, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    address = 7'd4; wdata = 32'h12345678; is_byte = 1'b0; is_half = 1'b0;
    write = 1'b1; rst = 1'b1;
    @(negedge clk);
    write = 1'b0; rst = 1'b0;
    load("rst_blocks_write", 7'd4, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
